bus_cycle_ctrl: RTL and testbench

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

---
 rtl/tmnt_bus_pkg.sv | 44 ++++
 rtl/bus_watchdog.sv | 52 +++++
 rtl/bus_cycle_ctrl.sv | 116 +++++++++++
 tb/tb_bus_cycle_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmnt_bus_pkg.sv
// Shared types and constants for the 68000 bus-cycle controller and its watchdog.
// Region codes match the encoding seen on the region output.
package tmnt_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_VWAIT,
    S_ACK,
    S_BERR
  } bus_state_t;

  localparam logic [2:0] REGION_ROM   = 3'd0;
  localparam logic [2:0] REGION_RAM   = 3'd1;
  localparam logic [2:0] REGION_PAL   = 3'd2;
  localparam logic [2:0] REGION_IO    = 3'd3;
  localparam logic [2:0] REGION_VIDEO = 3'd4;
  localparam logic [2:0] REGION_NONE  = 3'd7;

  localparam int WS_ROM_DEF     = 2;
  localparam int WS_RAM_DEF     = 0;
  localparam int WS_PAL_DEF     = 1;
  localparam int WS_IO_DEF      = 0;
  localparam int TIMEOUT_DEF    = 255;
  localparam int WDT_FRAMES_DEF = 8;
  localparam int WDT_PULSE      = 16;

  // a20_17 = {A20, A19, A18, A17}
  function automatic logic [2:0] decode_region(input logic [3:0] a20_17);
    logic [2:0] r;
    if (a20_17[3]) begin
      r = REGION_VIDEO;
    end else begin
      case (a20_17[2:0])
        3'd0, 3'd1, 3'd2: r = REGION_ROM;
        3'd3:             r = REGION_RAM;
        3'd4:             r = REGION_PAL;
        default:          r = REGION_IO;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Vblank watchdog: counts NVBLK falling edges since the last AFR kick and
// requests a 16-clock system reset when too many frames pass unkicked.
module bus_watchdog
  import tmnt_bus_pkg::*;
#(
  parameter int WDT_FRAMES = WDT_FRAMES_DEF
) (
  input  logic clk_main,
  input  logic nRESET,
  input  logic NVBLK,
  input  logic AFR,
  output logic wdt_rst
);

  localparam int CW = $clog2(WDT_FRAMES + 1);
  localparam int PW = $clog2(WDT_PULSE + 1);

  logic          nvblk_q;
  logic          afr_q;
  logic [CW-1:0] frames;
  logic [PW-1:0] pulse;
  logic          vfall;
  logic          kick;

  assign vfall = nvblk_q & ~NVBLK;
  assign kick  = afr_q & ~AFR;

  always_ff @(posedge clk_main) begin
    if (!nRESET) begin
      nvblk_q <= 1'b1;
      afr_q   <= 1'b1;
      frames  <= '0;
      pulse   <= '0;
    end else begin
      nvblk_q <= NVBLK;
      afr_q   <= AFR;
      // While the reset pulse runs, kicks are ignored; the frame count clears as it ends.
      if (pulse != '0) begin
        pulse <= pulse - 1'b1;
        if (pulse == PW'(1)) frames <= '0;
      end else if (kick) begin
        frames <= '0;
      end else if (vfall && frames != CW'(WDT_FRAMES)) begin
        frames <= frames + 1'b1;
        if (frames == CW'(WDT_FRAMES - 1)) pulse <= PW'(WDT_PULSE);
      end
    end
  end

  assign wdt_rst = (pulse != '0);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle controller: address decode, per-region wait states, chip
// DTACK for video, bus-error timeout, plus the vblank watchdog.
module bus_cycle_ctrl
  import tmnt_bus_pkg::*;
#(
  parameter int WS_ROM     = WS_ROM_DEF,
  parameter int WS_RAM     = WS_RAM_DEF,
  parameter int WS_PAL     = WS_PAL_DEF,
  parameter int WS_IO      = WS_IO_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int WDT_FRAMES = WDT_FRAMES_DEF
) (
  input  logic       clk_main,
  input  logic       nRESET,
  input  logic       nAS,
  input  logic [4:0] m68k_addr,
  input  logic       nUDS,
  input  logic       nLDS,
  input  logic       ODTAC,
  input  logic       VDTAC,
  input  logic       NVBLK,
  input  logic       AFR,
  output logic       nDTACK,
  output logic       nBERR,
  output logic [2:0] region,
  output logic       wdt_rst
);

  localparam int TW = $clog2(TIMEOUT + 1);

  bus_state_t    state;
  bus_state_t    state_nxt;
  logic [7:0]    wcnt;
  logic          wait_done;
  logic [TW-1:0] tcnt;
  logic [7:0]    ws_sel;
  logic          strobe;
  logic          dtac;
  logic          timed_out;
  logic          addr_unused;

  assign strobe      = ~nAS & (~nUDS | ~nLDS);
  assign dtac        = ~ODTAC | ~VDTAC;
  assign timed_out   = (tcnt == TW'(TIMEOUT - 1));
  assign region      = nAS ? REGION_NONE : decode_region(m68k_addr[4:1]);
  // A16 does not take part in decode.
  assign addr_unused = m68k_addr[0];

  always_comb begin
    ws_sel = 8'(WS_IO);
    case (decode_region(m68k_addr[4:1]))
      REGION_ROM: ws_sel = 8'(WS_ROM);
      REGION_RAM: ws_sel = 8'(WS_RAM);
      REGION_PAL: ws_sel = 8'(WS_PAL);
      default:    ws_sel = 8'(WS_IO);
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (!nRESET) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // wait_done lags the zero reading by one clock, giving WS+2 clocks strobe-to-DTACK.
  always_ff @(posedge clk_main) begin
    if (!nRESET) begin
      wcnt      <= '0;
      wait_done <= 1'b0;
      tcnt      <= '0;
    end else if (state == S_IDLE) begin
      wcnt      <= ws_sel;
      wait_done <= 1'b0;
      tcnt      <= '0;
    end else if (state == S_WAIT || state == S_VWAIT) begin
      tcnt <= tcnt + 1'b1;
      if (wcnt == '0) wait_done <= 1'b1;
      else            wcnt      <= wcnt - 1'b1;
    end
  end

  // Abort beats everything; acknowledge beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (strobe) state_nxt = m68k_addr[4] ? S_VWAIT : S_WAIT;
      S_WAIT: begin
        if (nAS)            state_nxt = S_IDLE;
        else if (wait_done) state_nxt = S_ACK;
        else if (timed_out) state_nxt = S_BERR;
      end
      S_VWAIT: begin
        if (nAS)            state_nxt = S_IDLE;
        else if (dtac)      state_nxt = S_ACK;
        else if (timed_out) state_nxt = S_BERR;
      end
      S_ACK, S_BERR: if (nAS) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    nDTACK = ~(state == S_ACK);
    nBERR  = ~(state == S_BERR);
  end

  bus_watchdog #(
    .WDT_FRAMES(WDT_FRAMES)
  ) u_wdt (
    .clk_main(clk_main),
    .nRESET  (nRESET),
    .NVBLK   (NVBLK),
    .AFR     (AFR),
    .wdt_rst (wdt_rst)
  );

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: directed bus/watchdog scenarios with a timing-level
// reference model compared every cycle, plus hand-computed literal expectations.
module tb_bus_cycle_ctrl;

  localparam int TB_TIMEOUT = 255;
  localparam int TB_WDT     = 8;
  localparam int TB_PULSE   = 16;

  logic       clk_main  = 1'b0;
  logic       nRESET    = 1'b0;
  logic       nAS       = 1'b1;
  logic [4:0] m68k_addr = 5'h00;
  logic       nUDS      = 1'b1;
  logic       nLDS      = 1'b1;
  logic       ODTAC     = 1'b1;
  logic       VDTAC     = 1'b1;
  logic       NVBLK     = 1'b1;
  logic       AFR       = 1'b1;
  logic       nDTACK;
  logic       nBERR;
  logic [2:0] region;
  logic       wdt_rst;

  bus_cycle_ctrl #(
    .WS_ROM(2), .WS_RAM(0), .WS_PAL(1), .WS_IO(0),
    .TIMEOUT(TB_TIMEOUT), .WDT_FRAMES(TB_WDT)
  ) dut (
    .clk_main (clk_main),
    .nRESET   (nRESET),
    .nAS      (nAS),
    .m68k_addr(m68k_addr),
    .nUDS     (nUDS),
    .nLDS     (nLDS),
    .ODTAC    (ODTAC),
    .VDTAC    (VDTAC),
    .NVBLK    (NVBLK),
    .AFR      (AFR),
    .nDTACK   (nDTACK),
    .nBERR    (nBERR),
    .region   (region),
    .wdt_rst  (wdt_rst)
  );

  always #5 clk_main = ~clk_main;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Region by A19:17 when A20=0, and wait states by region.
  int region_tab[8] = '{0, 0, 0, 1, 2, 3, 3, 3};
  int ws_by_region[4] = '{2, 0, 1, 0};

  function automatic int exp_region(input logic [4:0] a, input logic nas);
    if (nas) return 7;
    if (a[4]) return 4;
    return region_tab[a[3:1]];
  endfunction

  // Reference model in terms of edge indices: a cycle opened at edge s is
  // acknowledged at s+WS+2 (or at the first DTAC edge for video), errors at s+TIMEOUT.
  int n = 0;
  int cyc_start = 0;
  int ws = 0;
  int trig = -1000;
  int falls = 0;
  bit open = 0, acked = 0, berred = 0, vid = 0;
  bit pv = 1, pa = 1;
  bit model_ok = 0;
  bit exp_dtack_n = 1, exp_berr_n = 1, exp_wdt = 0;

  always @(posedge clk_main) begin
    n++;
    if (!nRESET) begin
      open = 0; acked = 0; berred = 0;
      falls = 0; trig = -1000; pv = 1; pa = 1;
      model_ok = 1;
    end else begin
      if (!open) begin
        if (!nAS && (!nUDS || !nLDS)) begin
          open = 1; acked = 0; berred = 0; cyc_start = n;
          vid = m68k_addr[4];
          ws = vid ? 0 : ws_by_region[region_tab[m68k_addr[3:1]]];
        end
      end else if (nAS) begin
        open = 0;
      end else if (!acked && !berred) begin
        if (vid ? (!ODTAC || !VDTAC) : (n - cyc_start >= ws + 2)) acked = 1;
        else if (n - cyc_start >= TB_TIMEOUT) berred = 1;
      end
      if (n > trig && n <= trig + TB_PULSE) begin
        if (n == trig + TB_PULSE) falls = 0;
      end else if (pa && !AFR) begin
        falls = 0;
      end else if (pv && !NVBLK) begin
        if (falls < TB_WDT) falls++;
        if (falls == TB_WDT) trig = n;
      end
      pv = NVBLK; pa = AFR;
    end
    exp_dtack_n = !(open && acked);
    exp_berr_n  = !(open && berred);
    exp_wdt     = (n >= trig && n < trig + TB_PULSE);
  end

  always @(negedge clk_main) begin
    if (model_ok) begin
      chk("model_dtack",  nDTACK,  exp_dtack_n);
      chk("model_berr",   nBERR,   exp_berr_n);
      chk("model_wdt",    wdt_rst, exp_wdt);
      chk("model_region", region,  exp_region(m68k_addr, nAS));
    end
  end

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic start_cycle(input logic [4:0] a, input logic uds, input logic lds);
    m68k_addr = a; nAS = 1'b0; nUDS = uds; nLDS = lds;
  endtask

  task automatic end_cycle();
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    tick();
  endtask

  // Edges after the strobe-sampling edge until nDTACK falls (-1 if never).
  task automatic lat_dtack(input int maxc, output int lat);
    lat = -1;
    tick();
    for (int k = 1; k <= maxc; k++) begin
      tick();
      if (!nDTACK) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic vblank();
    NVBLK = 1'b0; tick(); tick();
    NVBLK = 1'b1; tick(); tick(); tick();
  endtask

  logic [4:0] lat_addr[4] = '{5'h04, 5'h06, 5'h08, 5'h0A};
  int         lat_exp[4]  = '{4, 2, 3, 2};

  initial begin
    int lat, hi, first, seen;
    #200000;
    $display("FAIL global_timeout at t=%0t: got running expected finished", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat, hi, first, seen;
    repeat (3) tick();
    chk("rst_dtack",  nDTACK,  1);
    chk("rst_berr",   nBERR,   1);
    chk("rst_wdt",    wdt_rst, 0);
    chk("rst_region", region,  7);
    nRESET = 1'b1;
    tick();

    // Region decode sweep with no data strobe, so no cycle starts.
    for (int a = 0; a < 32; a++) begin
      m68k_addr = 5'(a); nAS = 1'b0;
      tick();
    end
    m68k_addr = 5'h16; #1 chk("region_video", region, 4);
    m68k_addr = 5'h07; #1 chk("region_ram_a16", region, 1);
    nAS = 1'b1; tick();

    // ROM read, WS_ROM=2
    start_cycle(5'h00, 1'b0, 1'b1);
    lat_dtack(20, lat);
    chk("rom_lat", lat, 4);
    tick();
    chk("rom_hold", nDTACK, 0);
    end_cycle();
    chk("rom_release", nDTACK, 1);

    for (int i = 0; i < 4; i++) begin
      start_cycle(lat_addr[i], 1'b1, 1'b0);
      lat_dtack(20, lat);
      chk("region_lat", lat, lat_exp[i]);
      end_cycle();
    end

    // VIDEO with VDTAC five clocks after strobe
    start_cycle(5'h10, 1'b1, 1'b0);
    tick();
    repeat (5) tick();
    chk("vid_wait_dtack", nDTACK, 1);
    chk("vid_region", region, 4);
    VDTAC = 1'b0;
    tick();
    chk("vid_dtack", nDTACK, 0);
    chk("vid_region_ack", region, 4);
    VDTAC = 1'b1;
    end_cycle();

    // VIDEO with no DTAC: bus error
    start_cycle(5'h10, 1'b0, 1'b0);
    lat = -1; seen = 0;
    tick();
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (!nDTACK) seen = 1;
      if (!nBERR) begin
        lat = k;
        break;
      end
    end
    chk("berr_lat", lat, 255);
    chk("berr_no_dtack", seen, 0);
    end_cycle();
    chk("berr_release", nBERR, 1);

    // DTAC on the timeout edge: acknowledge wins
    start_cycle(5'h12, 1'b0, 1'b1);
    tick();
    repeat (254) tick();
    ODTAC = 1'b0;
    tick();
    chk("tie_dtack", nDTACK, 0);
    chk("tie_berr", nBERR, 1);
    ODTAC = 1'b1;
    end_cycle();

    // Abort one clock into a ROM access
    start_cycle(5'h02, 1'b0, 1'b1);
    tick(); tick();
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    seen = 0;
    repeat (8) begin
      tick();
      if (!nDTACK || !nBERR) seen = 1;
    end
    chk("abort_quiet", seen, 0);
    start_cycle(5'h00, 1'b0, 1'b1);
    lat_dtack(20, lat);
    chk("abort_then_rom", lat, 4);

    // Reset while acknowledged, strobe still held
    nRESET = 1'b0;
    tick();
    chk("rst_ack_dtack", nDTACK, 1);
    nRESET = 1'b1;
    tick();
    chk("rst_ack_idle", nDTACK, 1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!nDTACK) begin
        lat = k;
        break;
      end
    end
    chk("rst_ack_restart", lat, 4);
    end_cycle();

    // Watchdog: 8 unkicked vblanks, AFR mid-pulse ignored
    repeat (7) vblank();
    NVBLK = 1'b0;
    hi = 0; first = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 0) first = int'(wdt_rst);
      if (k == 1) NVBLK = 1'b1;
      if (k == 4) AFR = 1'b0;
      if (k == 6) AFR = 1'b1;
      if (wdt_rst) hi++;
    end
    chk("wdt_first", first, 1);
    chk("wdt_len", hi, 16);

    // Same with a kick after the seventh vblank
    repeat (7) vblank();
    AFR = 1'b0; tick();
    AFR = 1'b1; tick();
    NVBLK = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 1) NVBLK = 1'b1;
      if (wdt_rst) seen = 1;
    end
    chk("wdt_kicked", seen, 0);

    // Reset mid-pulse
    nRESET = 1'b0; tick();
    nRESET = 1'b1; tick();
    repeat (7) vblank();
    NVBLK = 1'b0; tick();
    NVBLK = 1'b1; tick();
    chk("wdt_mid", wdt_rst, 1);
    nRESET = 1'b0; tick();
    chk("wdt_rst_drop", wdt_rst, 0);
    nRESET = 1'b1;
    repeat (20) tick();
    chk("wdt_stays_low", wdt_rst, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
